// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and frame helpers for the mode-0 SPI master
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    CS_GAP
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int RW_BIT = 15;
  localparam logic RW_WRITE = 1'b1;

  // Header {rw, addr} followed by the data byte; reads send a zero data byte.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic write,
                                                        input logic [6:0] addr,
                                                        input logic [7:0] wdata);
    logic [FRAME_BITS-1:0] frame;
    frame = '0;
    frame[RW_BIT] = write;
    frame[14:8] = addr;
    if (write == RW_WRITE) begin
      frame[7:0] = wdata;
    end
    return frame;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// rtl/spi_sck_gen.sv - SCK half-period tick generator
module spi_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick_rise,
  output logic tick_fall
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] half_cnt;
  logic          phase_high;
  logic          wrap;

  assign wrap      = en && (half_cnt == HALF_LAST);
  assign tick_rise = wrap && !phase_high;
  assign tick_fall = wrap && phase_high;

  // Count clk cycles within each SCK half; restart from the low phase whenever disabled.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      half_cnt   <= '0;
      phase_high <= 1'b0;
    end else if (wrap) begin
      half_cnt   <= '0;
      phase_high <= !phase_high;
    end else begin
      half_cnt   <= half_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_mode0_master.sv
// rtl/spi_mode0_master.sv - mode-0 SPI master issuing one 16-bit register access per request
module spi_mode0_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int ADDR_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  output logic [7:0]        rsp_rdata,
  output logic              busy,
  output logic              spi_cs,
  output logic              spi_clk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DLY_LAST = CW'(CLK_DIV - 1);

  state_t                state;
  state_t                state_next;
  logic [FRAME_BITS-1:0] tx_sh;
  logic [7:0]            rx_sh;
  logic [3:0]            bit_cnt;
  logic [CW-1:0]         dly_cnt;
  logic                  frame_rw;
  logic                  shift_en;
  logic                  tick_rise;
  logic                  tick_fall;
  logic                  accept;
  logic                  dly_done;
  logic                  last_bit;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign shift_en  = (state == SHIFT);
  // MOSI comes straight from the shift register flop, so it only moves when the register shifts.
  assign spi_mosi  = tx_sh[FRAME_BITS-1];

  spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (shift_en),
    .tick_rise (tick_rise),
    .tick_fall (tick_fall)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and per-cycle strobes.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    dly_done   = (dly_cnt == DLY_LAST);
    last_bit   = tick_fall && (bit_cnt == 4'd15);
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          state_next = CS_SETUP;
        end
      end
      CS_SETUP: if (dly_done) state_next = SHIFT;
      SHIFT:    if (last_bit) state_next = CS_HOLD;
      CS_HOLD:  if (dly_done) state_next = CS_GAP;
      CS_GAP:   if (dly_done) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Frame datapath: capture, shift out on SCK fall, sample MISO at the end of each high phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_sh     <= '0;
      rx_sh     <= '0;
      bit_cnt   <= '0;
      dly_cnt   <= '0;
      frame_rw  <= 1'b0;
      spi_cs    <= 1'b1;
      spi_clk   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            tx_sh    <= build_frame(req_write, 7'(req_addr), req_wdata);
            frame_rw <= req_write;
            rx_sh    <= '0;
            bit_cnt  <= '0;
            dly_cnt  <= '0;
            spi_cs   <= 1'b0;
          end
        end
        CS_SETUP: begin
          dly_cnt <= dly_done ? '0 : dly_cnt + CW'(1);
        end
        SHIFT: begin
          if (tick_rise) begin
            spi_clk <= 1'b1;
          end
          if (tick_fall) begin
            spi_clk <= 1'b0;
            if (bit_cnt[3]) begin
              rx_sh <= {rx_sh[6:0], spi_miso};
            end
            if (bit_cnt != 4'd15) begin
              bit_cnt <= bit_cnt + 4'd1;
              tx_sh   <= {tx_sh[FRAME_BITS-2:0], 1'b0};
            end
          end
        end
        CS_HOLD: begin
          dly_cnt <= dly_done ? '0 : dly_cnt + CW'(1);
          if (dly_done) begin
            spi_cs <= 1'b1;
            tx_sh  <= '0;
          end
        end
        CS_GAP: begin
          dly_cnt <= dly_done ? '0 : dly_cnt + CW'(1);
          if (dly_done) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= (frame_rw == RW_WRITE) ? 8'h00 : rx_sh;
          end
        end
        default: begin
          dly_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mode0_master.sv
// tb/tb_spi_mode0_master.sv - directed bench for spi_mode0_master with a register-slave model
module tb_spi_mode0_master;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       req_valid [2];
  logic       req_ready [2];
  logic       req_write [2];
  logic [6:0] req_addr  [2];
  logic [7:0] req_wdata [2];
  logic       rsp_valid [2];
  logic [7:0] rsp_rdata [2];
  logic       busy      [2];
  logic       spi_cs    [2];
  logic       spi_clk   [2];
  logic       spi_mosi  [2];
  logic       spi_miso  [2];

  int checks = 0;
  int failures = 0;

  int          s_cnt        [2];
  int          s_last_rises [2];
  logic [15:0] s_last_frame [2];
  int          err_sck      [2];
  int          err_mosi     [2];
  int          last_gap     [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Instance 0 runs at CLK_DIV=4, instance 1 at CLK_DIV=2; each has its own slave model and monitor.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int D = (g == 0) ? 4 : 2;

    spi_mode0_master #(.CLK_DIV(D), .ADDR_W(7)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_write (req_write[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .busy      (busy[g]),
      .spi_cs    (spi_cs[g]),
      .spi_clk   (spi_clk[g]),
      .spi_mosi  (spi_mosi[g]),
      .spi_miso  (spi_miso[g])
    );

    logic [15:0] sh;
    logic        rw;
    logic [7:0]  out;
    logic [7:0]  mem [24];
    logic [23:0] wr_ok = '0;

    // Registers 0..22 read/write, 23 read-only 0x5A, anything above reads 0xFF.
    function automatic logic [7:0] rd_reg(input logic [6:0] a);
      if (a > 7'd23) return 8'hFF;
      if (wr_ok[a[4:0]]) return mem[a[4:0]];
      if (a == 7'd2) return 8'h3C;
      if (a == 7'd23) return 8'h5A;
      return 8'h00;
    endfunction

    always @(posedge spi_clk[g] or posedge spi_cs[g]) begin
      if (spi_cs[g]) begin
        s_last_rises[g] = s_cnt[g];
        s_cnt[g] = 0;
      end else begin
        sh = {sh[14:0], spi_mosi[g]};
        s_cnt[g] = s_cnt[g] + 1;
        if (s_cnt[g] == 8) begin
          rw = sh[7];
          out = rd_reg(sh[6:0]);
        end
        if (s_cnt[g] == 16) begin
          s_last_frame[g] = sh;
          if (rw && sh[14:8] < 7'd23) begin
            mem[sh[12:8]] = sh[7:0];
            wr_ok[sh[12:8]] = 1'b1;
          end
        end
      end
    end

    // Slave drives 1s during a write's data byte so the master must still report 0x00.
    always @(negedge spi_clk[g] or posedge spi_cs[g]) begin
      if (spi_cs[g]) spi_miso[g] = 1'b0;
      else if (s_cnt[g] >= 8 && s_cnt[g] < 16) spi_miso[g] = rw ? 1'b1 : out[15 - s_cnt[g]];
    end

    int   run;
    int   cs_run;
    logic p_sck, p_cs, p_mosi, after_fall;

    always @(negedge clk) begin
      if (!rst_n) begin
        run = 0;
        cs_run = 0;
        after_fall = 1'b0;
      end else begin
        if (spi_clk[g] !== p_sck) begin
          if (p_sck && run != D) err_sck[g]++;
          if (!p_sck && after_fall && run != D) err_sck[g]++;
          if (p_sck) after_fall = 1'b1;
          run = 1;
        end else begin
          run++;
        end
        if (spi_mosi[g] !== p_mosi && spi_cs[g] === p_cs && !(p_sck && !spi_clk[g])) err_mosi[g]++;
        if (spi_cs[g] !== p_cs) begin
          if (!spi_cs[g]) begin
            last_gap[g] = cs_run;
            after_fall = 1'b0;
          end
          cs_run = 1;
        end else begin
          cs_run++;
        end
      end
      p_sck = spi_clk[g];
      p_cs = spi_cs[g];
      p_mosi = spi_mosi[g];
    end
  end

  task automatic wait_rsp(input int i, output int lat);
    lat = 1;
    while (rsp_valid[i] !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 400) check_eq("rsp_timeout", rsp_valid[i], 1);
  endtask

  task automatic do_req(input int i, input logic w, input logic [6:0] a, input logic [7:0] d,
                        output int lat, output logic [7:0] rd);
    @(negedge clk);
    req_write[i] = w;
    req_addr[i] = a;
    req_wdata[i] = d;
    req_valid[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[i] = 1'b0;
    wait_rsp(i, lat);
    rd = rsp_rdata[i];
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    int pulses;
    logic [7:0] rd;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_addr[i] = '0;
      req_wdata[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("reset_pins%0d", i),
               {spi_cs[i], spi_clk[i], spi_mosi[i], rsp_valid[i], busy[i], req_ready[i]}, 6'b100001);
      check_eq($sformatf("reset_rdata%0d", i), rsp_rdata[i], 8'h00);
    end

    // Write addr 0x05 data 0xA5.
    do_req(0, 1'b1, 7'h05, 8'hA5, lat, rd);
    check_eq("wr_latency", lat, 141);
    check_eq("wr_rdata", rd, 8'h00);
    check_eq("wr_frame", s_last_frame[0], 16'h85A5);
    check_eq("wr_rises", s_last_rises[0], 16);
    @(negedge clk);
    check_eq("rsp_one_cycle", {rsp_valid[0], busy[0]}, 2'b00);

    // Read addr 0x02, slave returns 0x3C.
    do_req(0, 1'b0, 7'h02, 8'hEE, lat, rd);
    check_eq("rd_latency", lat, 141);
    check_eq("rd_rdata", rd, 8'h3C);
    check_eq("rd_frame", s_last_frame[0], 16'h0200);

    // Back-to-back with req_valid held, inputs changing mid-frame.
    @(negedge clk);
    req_write[0] = 1'b1;
    req_addr[0] = 7'h05;
    req_wdata[0] = 8'h11;
    req_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n = 1;
    while (rsp_valid[0] !== 1'b1 && n < 400) begin
      if (n < 100) begin
        req_write[0] = 1'($urandom);
        req_addr[0] = 7'($urandom);
        req_wdata[0] = 8'($urandom);
      end else begin
        req_write[0] = 1'b0;
        req_addr[0] = 7'h02;
        req_wdata[0] = 8'hFF;
      end
      @(negedge clk);
      n++;
    end
    check_eq("b2b_lat1", n, 141);
    check_eq("b2b_ready_on_rsp", req_ready[0], 1'b1);
    check_eq("b2b_frame1", s_last_frame[0], 16'h8511);
    @(posedge clk);
    @(negedge clk);
    check_eq("b2b_accepted", busy[0], 1'b1);
    req_valid[0] = 1'b0;
    n = 1;
    while (rsp_valid[0] !== 1'b1 && n < 400) begin
      if (n < 60) begin
        req_write[0] = 1'($urandom);
        req_addr[0] = 7'($urandom);
        req_wdata[0] = 8'($urandom);
      end
      @(negedge clk);
      n++;
    end
    check_eq("b2b_lat2", n, 141);
    check_eq("b2b_rdata2", rsp_rdata[0], 8'h3C);
    check_eq("b2b_frame2", s_last_frame[0], 16'h0200);
    check_eq("cs_gap_min", last_gap[0] >= 4, 1'b1);
    check_eq("cs_gap", last_gap[0], 5);
    check_eq("sck_widths", err_sck[0], 0);
    check_eq("mosi_stable", err_mosi[0], 0);

    // Reset during bit 6 of the shift phase.
    @(negedge clk);
    req_write[0] = 1'b1;
    req_addr[0] = 7'h0A;
    req_wdata[0] = 8'h3C;
    req_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 0;
    while (!(s_cnt[0] == 6 && spi_clk[0] == 1'b0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_reach_bit6", s_cnt[0], 6);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_mid_pins",
             {spi_cs[0], spi_clk[0], spi_mosi[0], rsp_valid[0], busy[0], req_ready[0]}, 6'b100001);
    check_eq("rst_mid_rises", s_last_rises[0], 6);
    rst_n = 1'b1;
    pulses = 0;
    repeat (300) begin
      @(negedge clk);
      if (rsp_valid[0] === 1'b1) pulses++;
    end
    check_eq("rst_no_rsp", pulses, 0);
    do_req(0, 1'b1, 7'h0A, 8'h3C, lat, rd);
    check_eq("post_rst_lat", lat, 141);
    check_eq("post_rst_frame", s_last_frame[0], 16'h8A3C);
    do_req(0, 1'b0, 7'h0A, 8'h00, lat, rd);
    check_eq("post_rst_read", rd, 8'h3C);

    // Loopback at both dividers.
    for (int i = 0; i < 2; i++) begin
      do_req(i, 1'b1, 7'h03, 8'h12, lat, rd);
      check_eq($sformatf("lb%0d_wr_lat", i), lat, (i == 0) ? 141 : 71);
      do_req(i, 1'b0, 7'h03, 8'h00, lat, rd);
      check_eq($sformatf("lb%0d_rd3", i), rd, 8'h12);
      do_req(i, 1'b0, 7'h7F, 8'h00, lat, rd);
      check_eq($sformatf("lb%0d_rd7f", i), rd, 8'hFF);
      check_eq($sformatf("lb%0d_frame7f", i), s_last_frame[i], 16'h7F00);
      do_req(i, 1'b1, 7'd23, 8'h77, lat, rd);
      do_req(i, 1'b0, 7'd23, 8'h00, lat, rd);
      check_eq($sformatf("lb%0d_ro", i), rd, 8'h5A);
      check_eq($sformatf("lb%0d_sck", i), err_sck[i], 0);
      check_eq($sformatf("lb%0d_mosi", i), err_mosi[i], 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
